// File: rtl/clap_decoder.sv
// clap_decoder: synchronises and debounces the microphone sound level,
// detects individual claps, groups closely spaced claps into a 1-3 clap
// command and offers it to the game controller on a valid/ready handshake.
module clap_decoder #(
    parameter int DEBOUNCE_CYC = 50_000,
    parameter int WINDOW_CYC   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sound_level,
    output logic       cmd_valid,
    output logic [1:0] cmd_count,
    input  logic       cmd_ready,
    output logic       clap_pulse,
    output logic       busy
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PEND    = 2'd2
    } state_t;

    logic          r_sync1, r_sync2;
    logic          r_deb, r_deb_d;
    logic [DW-1:0] r_dcnt;
    logic          r_clap_pulse;

    state_t        r_state, w_state;
    logic [1:0]    r_count, w_count;
    logic [TW-1:0] r_timer, w_timer;
    logic          r_cmd_valid, w_cmd_valid;
    logic [1:0]    r_cmd_count, w_cmd_count;

    // Two-flop synchroniser; sound_level is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sound_level;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: level follows sync only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_deb  <= 1'b0;
            r_dcnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_LAST) begin
            r_deb  <= r_sync2;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + DW'(1);
        end
    end

    // Registered rising-edge detect of the debounced level gives one pulse per clap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_deb_d      <= 1'b0;
            r_clap_pulse <= 1'b0;
        end else begin
            r_deb_d      <= r_deb;
            r_clap_pulse <= r_deb & ~r_deb_d;
        end
    end

    // FSM and command register state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_count     <= 2'd0;
            r_timer     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_count <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_timer     <= w_timer;
            r_cmd_valid <= w_cmd_valid;
            r_cmd_count <= w_cmd_count;
        end
    end

    // Next-state logic: a clap beats a coinciding timeout; claps during PEND are dropped.
    always_comb begin
        w_state     = r_state;
        w_count     = r_count;
        w_timer     = r_timer;
        w_cmd_valid = r_cmd_valid;
        w_cmd_count = r_cmd_count;
        case (r_state)
            IDLE: begin
                if (r_clap_pulse) begin
                    w_state = COLLECT;
                    w_count = 2'd1;
                    w_timer = '0;
                end
            end
            COLLECT: begin
                if (r_clap_pulse) begin
                    w_count = (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
                    w_timer = '0;
                end else if (r_timer == TIMER_LAST) begin
                    w_state     = PEND;
                    w_cmd_valid = 1'b1;
                    w_cmd_count = r_count;
                    w_timer     = '0;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            PEND: begin
                if (r_cmd_valid && cmd_ready) begin
                    w_state     = IDLE;
                    w_cmd_valid = 1'b0;
                    w_cmd_count = 2'd0;
                    w_count     = 2'd0;
                end
            end
            default: begin
                w_state     = IDLE;
                w_count     = 2'd0;
                w_timer     = '0;
                w_cmd_valid = 1'b0;
                w_cmd_count = 2'd0;
            end
        endcase
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_count  = r_cmd_count;
    assign clap_pulse = r_clap_pulse;
    assign busy       = (r_state != IDLE);

endmodule

// File: doc/clap_decoder.md
# clap_decoder

Downstream consumer of the microphone sound-detect level in the Battleship input path. It synchronises and debounces the 1-bit sound level and detects individual claps. It then groups claps that arrive close together into a command with a clap count of 1–3 and presents that command on a valid/ready handshake to the game controller. The player uses 1, 2 or 3 claps for move, rotate and fire.

## Interface

Parameters:
- DEBOUNCE_CYC, default 50_000: number of consecutive cycles the synchronised input must differ from the debounced level before that level changes (1 ms at 50 MHz). Must be ≥ 2.
- WINDOW_CYC, default 25_000_000: maximum quiet cycles after a clap before the group closes (0.5 s at 50 MHz). Must be ≥ 2.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, synchronous, active-low. Clock is clk.
- sound_level, in, 1: sound-detected level. Asynchronous to clk.
- cmd_valid, out, 1: a command is pending.
- cmd_count, out, 2: number of claps in the command (1–3). Stable while cmd_valid is high.
- cmd_ready, in, 1: the consumer accepts the command.
- clap_pulse, out, 1: one-cycle pulse per debounced rising edge (debug/LED).
- busy, out, 1: high when the FSM is not in IDLE.

## Operation

- **Synchroniser:** two-flop synchroniser on sound_level gives sync. Both flops reset to 0.
- **Debouncer:**
  - Maintains debounced level deb and counter dcnt.
  - If sync == deb, dcnt <= 0.
  - Otherwise, if dcnt == DEBOUNCE_CYC-1: deb <= sync and dcnt <= 0.
  - Otherwise dcnt increments.
  - dcnt width is $clog2(DEBOUNCE_CYC). It never wraps.
- **Clap detect:** clap_pulse is registered, equal to deb & ~deb_d, where deb_d is deb delayed one cycle.
- **FSM states:**
  - IDLE: on clap_pulse, go to COLLECT with count=1 and timer=0.
  - COLLECT:
    - Each cycle without clap_pulse, timer increments.
    - On clap_pulse: count <= min(count+1, 3) (saturating) and timer <= 0.
    - When timer == WINDOW_CYC-1 with no clap_pulse in that cycle: go to PEND, cmd_valid <= 1, cmd_count <= count.
    - If clap_pulse and timeout coincide, the clap wins: it is counted and the timer restarts.
  - PEND:
    - cmd_valid and cmd_count hold.
    - clap_pulse is ignored and discarded, not queued.
    - When cmd_valid & cmd_ready: cmd_valid <= 0, cmd_count <= 0, go to IDLE.
- **Handshake:**
  - cmd_ready while cmd_valid is low has no effect.
  - cmd_valid never drops without a handshake, except on reset.
- **Outputs:** busy = (state != IDLE).
- **Reset:** reset values are cmd_valid 0, cmd_count 0, clap_pulse 0, busy 0, state IDLE, deb 0, dcnt 0, timer 0, count 0. A reset in any state aborts the current group.

## Timing

- **Clap latency:**
  - sound_level is first sampled high at edge 0 and stays high.
  - sync is high after edge 1.
  - deb is set at edge DEBOUNCE_CYC+1.
  - clap_pulse is high for exactly one cycle, following edge DEBOUNCE_CYC+2.
- **Glitch rejection:** a high pulse of ≤ DEBOUNCE_CYC-1 sampled cycles produces no clap. Falling edges are debounced identically, so a clap counts only after a debounced low.
- **FSM update:** the FSM samples clap_pulse at the next edge, DEBOUNCE_CYC+3.
- **Command timing:** with the last clap accepted at edge t, cmd_valid rises after edge t+WINDOW_CYC.
- **Handshake timing:**
  - A handshake at edge h clears cmd_valid after edge h.
  - A clap_pulse sampled at edge h is discarded.
  - A clap_pulse at h+1 starts a new group.
- **Throughput:** 1 command per handshake. No buffering.

## Test plan

All scenarios use DEBOUNCE_CYC=4, WINDOW_CYC=20 and cmd_ready tied high unless stated.

- **Single clap:** sound_level high for 10 cycles then low → one clap_pulse 6 edges after first sample; cmd_valid for 1 cycle 20 edges after the clap is accepted, with cmd_count=1; afterwards cmd_count=0 and busy=0.
- **Glitch rejection:** sound_level high 3 cycles, low 10, repeated 5× → clap_pulse never asserts and busy stays 0.
- **Grouping and saturation:**
  - Three 8-cycle claps separated by 10 low cycles → one command with cmd_count=3.
  - Five such claps → cmd_count=3 (saturated).
- **Window expiry:** two claps with 30 low cycles between them → two commands, each with cmd_count=1.
- **Backpressure:**
  - Setup: cmd_ready low; two claps → PEND.
  - While ready is low: hold ready low 50 cycles while clapping twice more → cmd_valid stays high and cmd_count stays 2.
  - Release: raise ready → valid drops the next edge; the discarded claps produce no command.
- **Reset mid-COLLECT:** reset_n low for 1 edge after the first clap → all outputs 0 and state IDLE; no command emitted afterwards.
